// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory controller.
// Packs 64-bit host load words into 128-bit lines and writes them to the
// single-port instruction memory. When the load ends it pulses start_vld to
// the fetch unit, then passes the fetch unit's read requests straight to
// memory until the host halts the core.
// Optional build macro IMEM_DROP_ERR_EN adds a sticky drop_err output that
// flags fetch requests made while the controller owns the memory port.
module imem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_wr_vld,
    output logic                  host_wr_rdy,
    input  logic [63:0]           host_wr_data,
    input  logic                  host_wr_last,
    input  logic [11:0]           host_boot_addr,
    input  logic                  host_halt,
    output logic                  start_vld,
    output logic [11:0]           start_addr,
    input  logic                  ifu_mem_ce,
    input  logic [ADDR_WIDTH-1:0] ifu_mem_addr,
    output logic                  mem_we,
    output logic                  mem_ce,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
`ifdef IMEM_DROP_ERR_EN
    output logic                  drop_err,
`endif
    output logic                  run
);

    localparam int HW = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_BOOT,
        S_RUN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] ptr_inc;
    logic [HW-1:0]     lo_buf;
    logic              pend;
    logic              load_phase;
    logic              accept;
    logic              odd_beat;
    logic              last_beat;

    // Only IDLE and LOAD take host words; kept outside the FSM block so the
    // handshake has no combinational loop through host_wr_rdy.
    assign load_phase  = (state == S_IDLE) || (state == S_LOAD);
    assign host_wr_rdy = load_phase;
    assign accept      = host_wr_vld && load_phase;
    assign odd_beat    = wr_ptr[0];
    // The beat at the all-ones pointer fills the memory and is forced last.
    assign last_beat   = host_wr_last || (&wr_ptr);
    assign ptr_inc     = wr_ptr + 1'b1;

    // Next-state and output decode; memory port is muxed by state.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_nxt = state;
        start_vld = 1'b0;
        run       = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (odd_beat) begin
                        mem_ce   = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = wr_ptr[ADDR_WIDTH:1];
                        mem_din  = {host_wr_data, lo_buf};
                    end
                    if (last_beat) begin
                        state_nxt = odd_beat ? S_BOOT : S_FLUSH;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                // Odd word count: write the pending low half with a zero upper half.
                mem_ce    = pend;
                mem_we    = pend;
                mem_addr  = wr_ptr[ADDR_WIDTH:1];
                mem_din   = {{HW{1'b0}}, lo_buf};
                state_nxt = S_BOOT;
            end
            S_BOOT: begin
                start_vld = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Zero-latency pass-through keeps the fetch unit's read timing.
                run      = 1'b1;
                mem_ce   = ifu_mem_ce;
                mem_addr = ifu_mem_addr;
                if (host_halt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, word pointer, half-line buffer and boot address.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            lo_buf     <= '0;
            pend       <= 1'b0;
            start_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_ptr <= ptr_inc;
                if (!odd_beat) begin
                    lo_buf <= host_wr_data;
                    pend   <= 1'b1;
                end else begin
                    pend   <= 1'b0;
                end
                if (last_beat) begin
                    start_addr <= host_boot_addr & 12'hFF8;
                end
            end
            if (state == S_FLUSH) begin
                pend <= 1'b0;
            end
            if ((state == S_RUN) && host_halt) begin
                wr_ptr <= '0;
                pend   <= 1'b0;
            end
        end
    end

`ifdef IMEM_DROP_ERR_EN
    // Sticky flag for fetch requests dropped outside RUN; a request in the
    // same cycle as the IDLE->LOAD clear still counts as dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (ifu_mem_ce && (state != S_RUN)) begin
            drop_err <= 1'b1;
        end else if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
            drop_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: table-driven bench for imem_ctrl. Each vector drives one
// cycle of inputs and lists the expected handshake/control outputs; memory
// writes are predicted by a small packing model into a scoreboard queue and
// compared by a monitor whenever the DUT writes.
module tb_imem_ctrl;

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic        last;
        logic [11:0] boot;
        logic        halt;
        logic        ifu_ce;
        logic [7:0]  ifu_addr;
        logic        e_rdy;
        logic        e_sv;
        logic [11:0] e_sa;
        logic        e_run;
        logic        e_ce;
        logic        e_we;
        logic [7:0]  e_addr;
    } vec_t;

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] din;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         host_wr_vld;
    logic         host_wr_rdy;
    logic [63:0]  host_wr_data;
    logic         host_wr_last;
    logic [11:0]  host_boot_addr;
    logic         host_halt;
    logic         start_vld;
    logic [11:0]  start_addr;
    logic         ifu_mem_ce;
    logic [7:0]   ifu_mem_addr;
    logic         mem_we;
    logic         mem_ce;
    logic [7:0]   mem_addr;
    logic [127:0] mem_din;
    logic         run;
`ifdef IMEM_DROP_ERR_EN
    logic         drop_err;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  sb[$];
    wr_t  mon_e;
    logic [8:0]  m_ptr = '0;
    logic [63:0] m_lo  = '0;
    vec_t tbl[13];

    imem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(128)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_wr_vld   (host_wr_vld),
        .host_wr_rdy   (host_wr_rdy),
        .host_wr_data  (host_wr_data),
        .host_wr_last  (host_wr_last),
        .host_boot_addr(host_boot_addr),
        .host_halt     (host_halt),
        .start_vld     (start_vld),
        .start_addr    (start_addr),
        .ifu_mem_ce    (ifu_mem_ce),
        .ifu_mem_addr  (ifu_mem_addr),
        .mem_we        (mem_we),
        .mem_ce        (mem_ce),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
`ifdef IMEM_DROP_ERR_EN
        .drop_err      (drop_err),
`endif
        .run           (run)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] w(input logic [7:0] t, input int i);
        logic [23:0] lo = 24'(i);
        return {t, 24'hA5C3E1, ~t, lo ^ 24'h3C3C3C};
    endfunction

    function automatic vec_t mk(
        input logic vld, input logic [63:0] data, input logic last,
        input logic [11:0] boot, input logic halt, input logic ifu_ce,
        input logic [7:0] ifu_addr, input logic e_rdy, input logic e_sv,
        input logic [11:0] e_sa, input logic e_run, input logic e_ce,
        input logic e_we, input logic [7:0] e_addr);
        vec_t v;
        v.vld = vld;      v.data = data;   v.last = last;   v.boot = boot;
        v.halt = halt;    v.ifu_ce = ifu_ce; v.ifu_addr = ifu_addr;
        v.e_rdy = e_rdy;  v.e_sv = e_sv;   v.e_sa = e_sa;   v.e_run = e_run;
        v.e_ce = e_ce;    v.e_we = e_we;   v.e_addr = e_addr;
        return v;
    endfunction

    // Drive one cycle, update the packing model, check outputs at negedge.
    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        host_wr_vld    = v.vld;
        host_wr_data   = v.data;
        host_wr_last   = v.last;
        host_boot_addr = v.boot;
        host_halt      = v.halt;
        ifu_mem_ce     = v.ifu_ce;
        ifu_mem_addr   = v.ifu_addr;
        if (v.vld && v.e_rdy) begin
            if (!m_ptr[0]) m_lo = v.data;
            else sb.push_back(wr_t'{m_ptr[8:1], {v.data, m_lo}});
            m_ptr = m_ptr + 9'd1;
            if (v.last && m_ptr[0]) sb.push_back(wr_t'{m_ptr[8:1], {64'h0, m_lo}});
        end
        if (v.halt && v.e_run) m_ptr = '0;
        @(negedge clk);
        check({tag, ".rdy"}, host_wr_rdy, v.e_rdy);
        check({tag, ".start_vld"}, start_vld, v.e_sv);
        check({tag, ".run"}, run, v.e_run);
        check({tag, ".mem_ce"}, mem_ce, v.e_ce);
        check({tag, ".mem_we"}, mem_we, v.e_we);
        if (v.e_sv) check({tag, ".start_addr"}, start_addr, v.e_sa);
        if (v.e_ce) check({tag, ".mem_addr"}, mem_addr, v.e_addr);
        if (!v.e_we) check({tag, ".mem_din"}, mem_din, '0);
    endtask

    // Every memory write must match the next predicted line in order.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got write to line %h, required none", mem_addr);
            end else begin
                mon_e = sb.pop_front();
                check("wr_line", 128'(mem_addr), 128'(mon_e.addr));
                check("wr_data", mem_din, mon_e.din);
            end
        end
    end

    initial begin
        rst = 1'b1;
        host_wr_vld = 1'b0; host_wr_data = '0; host_wr_last = 1'b0;
        host_boot_addr = '0; host_halt = 1'b0; ifu_mem_ce = 1'b0; ifu_mem_addr = '0;

        // Four-word load, run, halt with a live request, restart at line 0.
        tbl[0]  = mk(1, w(8'hD0,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, w(8'hD0,1), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h00);
        tbl[2]  = mk(1, w(8'hD0,2), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00);
        tbl[3]  = mk(1, w(8'hD0,3), 1, 12'h013, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h01);
        tbl[4]  = mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 1, 12'h010, 0, 0, 0, 8'h00);
        tbl[5]  = mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00);
        tbl[6]  = mk(0, 64'h0,      0, 12'h000, 0, 1, 8'h05, 0, 0, 12'h000, 1, 1, 0, 8'h05);
        tbl[7]  = mk(0, 64'h0,      0, 12'h000, 1, 1, 8'h07, 0, 0, 12'h000, 1, 1, 0, 8'h07);
        tbl[8]  = mk(1, w(8'hE0,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00);
        tbl[9]  = mk(1, w(8'hE0,1), 1, 12'hFFF, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h00);
        tbl[10] = mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 1, 12'hFF8, 0, 0, 0, 8'h00);
        tbl[11] = mk(0, 64'h0,      0, 12'h000, 1, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00);
        tbl[12] = mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.rdy", host_wr_rdy, 1'b1);
        check("reset.start_vld", start_vld, 1'b0);
        check("reset.start_addr", start_addr, 12'h000);
        check("reset.run", run, 1'b0);
        check("reset.mem_we", mem_we, 1'b0);
        check("reset.mem_ce", mem_ce, 1'b0);
`ifdef IMEM_DROP_ERR_EN
        check("reset.drop_err", drop_err, 1'b0);
`endif

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("t1[%0d]", i));

        // Odd word count: FLUSH writes the lone low half; requests in LOAD drop.
        apply(mk(1, w(8'hF0,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "odd.w0");
        apply(mk(1, w(8'hF0,1), 0, 12'h000, 0, 1, 8'h33, 1, 0, 12'h000, 0, 1, 1, 8'h00), "odd.w1");
        apply(mk(1, w(8'hF0,2), 1, 12'h123, 0, 1, 8'h44, 1, 0, 12'h000, 0, 0, 0, 8'h00), "odd.w2");
        apply(mk(1, w(8'hF0,3), 0, 12'h000, 0, 0, 8'h00, 0, 0, 12'h000, 0, 1, 1, 8'h01), "odd.flush");
        apply(mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 1, 12'h120, 0, 0, 0, 8'h00), "odd.boot");
        apply(mk(0, 64'h0,      0, 12'h000, 1, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00), "odd.run");
        apply(mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "odd.idle");

        // Fill all 512 words with no last: line 255 on word 511, then BOOT.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] ib;
            ib = 9'(i);
            apply(mk(1, w(8'h55,i), 0, 12'hABC, 0, 0, 8'h00, 1, 0, 12'h000, 0,
                     ib[0], ib[0], ib[8:1]), $sformatf("full[%0d]", i));
        end
        apply(mk(1, w(8'h55,512), 0, 12'h000, 0, 0, 8'h00, 0, 1, 12'hAB8, 0, 0, 0, 8'h00), "full.boot");
        apply(mk(1, w(8'h55,513), 0, 12'h000, 0, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00), "full.run");
        apply(mk(0, 64'h0,        0, 12'h000, 1, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00), "full.halt");
        apply(mk(0, 64'h0,        0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "full.idle");

        // Reset after one word of a load: half-line discarded, pointer back to 0.
        apply(mk(1, w(8'h77,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "rst.w0");
        @(posedge clk);
        #1 rst = 1'b1;
        host_wr_vld = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = '0;
        @(negedge clk);
        check("rst.rdy", host_wr_rdy, 1'b1);
        check("rst.start_vld", start_vld, 1'b0);
        check("rst.start_addr", start_addr, 12'h000);
        check("rst.run", run, 1'b0);
        check("rst.mem_we", mem_we, 1'b0);
        check("rst.mem_ce", mem_ce, 1'b0);
        apply(mk(1, w(8'h88,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "rst.x0");
        apply(mk(1, w(8'h88,1), 1, 12'h80F, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h00), "rst.x1");
        apply(mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 1, 12'h808, 0, 0, 0, 8'h00), "rst.boot");
        apply(mk(0, 64'h0,      0, 12'h000, 1, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00), "rst.run");
        apply(mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "rst.idle");

`ifdef IMEM_DROP_ERR_EN
        // Dropped request in LOAD sets drop_err; it holds until the next load starts.
        apply(mk(1, w(8'h99,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "de.y0");
        check("de.clear", drop_err, 1'b0);
        apply(mk(0, 64'h0,      0, 12'h000, 0, 1, 8'h03, 1, 0, 12'h000, 0, 0, 0, 8'h00), "de.req");
        apply(mk(1, w(8'h99,1), 1, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h00), "de.y1");
        check("de.set", drop_err, 1'b1);
        apply(mk(0, 64'h0,      0, 12'h000, 0, 0, 8'h00, 0, 1, 12'h000, 0, 0, 0, 8'h00), "de.boot");
        apply(mk(0, 64'h0,      0, 12'h000, 1, 0, 8'h00, 0, 0, 12'h000, 1, 0, 0, 8'h00), "de.run");
        check("de.hold_run", drop_err, 1'b1);
        apply(mk(1, w(8'hAA,0), 0, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 8'h00), "de.z0");
        check("de.hold_idle", drop_err, 1'b1);
        apply(mk(1, w(8'hAA,1), 1, 12'h000, 0, 0, 8'h00, 1, 0, 12'h000, 0, 1, 1, 8'h00), "de.z1");
        check("de.cleared", drop_err, 1'b0);
`endif

        @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Owns the single-port 256x128 instruction memory (mem_wrapper instance).
- Sequences a host program load: 64-bit host words are packed into 128-bit lines and written into the memory.
- Issues the one-cycle start pulse to the fetch unit, then hands the memory read port to the fetch unit until the host halts the core.
- Sits between the host loader, the fetch unit's memory request lines and the mem_wrapper.

Parameters:
- ADDR_WIDTH, 8, memory line-address width; lines = 2^ADDR_WIDTH.
- DATA_WIDTH, 128, memory line width; fixed at 2x host word width (64).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- host_wr_vld  in  1  host load word valid
- host_wr_rdy  out  1  controller accepts load word
- host_wr_data  in  64  load word; word n is stored at byte address 8n
- host_wr_last  in  1  qualifies final load word
- host_boot_addr  in  12  fetch start byte address; sampled on the last accepted word
- host_halt  in  1  leave RUN and return to IDLE
- start_vld  out  1  one-cycle start pulse to the fetch unit
- start_addr  out  12  boot address accompanying start_vld
- ifu_mem_ce  in  1  fetch-unit memory read enable
- ifu_mem_addr  in  ADDR_WIDTH  fetch-unit line address
- mem_we  out  1  memory write enable
- mem_ce  out  1  memory chip enable
- mem_addr  out  ADDR_WIDTH  memory line address
- mem_din  out  DATA_WIDTH  memory write data
- run  out  1  high in RUN

Behaviour:
- States: IDLE, LOAD, FLUSH, BOOT, RUN. Reset enters IDLE.
- Reset values:
  - start_vld=0, start_addr=0, run=0, mem_we=0, mem_ce=0.
  - Word pointer wr_ptr[ADDR_WIDTH:0]=0, low-half buffer lo_buf=0, pending-half flag=0.
- host_wr_rdy = 1 in IDLE and LOAD, else 0. A beat is accepted when host_wr_vld & host_wr_rdy.
- Beat packing:
  - An accepted beat with wr_ptr[0]=0 stores host_wr_data in lo_buf and sets the pending flag; no memory write occurs.
  - An accepted beat with wr_ptr[0]=1 writes the line in the same cycle: mem_ce=mem_we=1, mem_addr=wr_ptr[ADDR_WIDTH:1], mem_din={host_wr_data, lo_buf}. The pending flag clears.
  - wr_ptr increments by 1 on every accepted beat.
- IDLE -> LOAD on the first accepted beat that is not last.
- Last beat (host_wr_last, or the beat that makes wr_ptr reach 2^(ADDR_WIDTH+1), i.e. the memory is full):
  - Latch start_addr={host_boot_addr[11:3], 3'b000}.
  - If the beat is odd, the line is written as above and the state goes to BOOT.
  - If the beat is even, the state goes to FLUSH.
  - A last beat accepted in IDLE takes the same transitions.
- FLUSH (1 cycle): mem_ce=mem_we=1, mem_addr=wr_ptr[ADDR_WIDTH:1] using the post-increment pointer, mem_din={64'b0, lo_buf}. Then go to BOOT.
- BOOT (1 cycle): start_vld=1 with start_addr valid; mem port is idle. Then go to RUN.
- RUN:
  - mem_ce=ifu_mem_ce, mem_addr=ifu_mem_addr, mem_we=0, mem_din=0. The path is combinational, with zero added latency, so the fetch unit's 1-cycle read timing is preserved.
  - run=1.
- Fetch requests outside RUN are dropped: mem_ce is driven only by the controller. The fetch unit cannot issue requests before start_vld, so BOOT needs no conflict handling.
- host_halt in RUN:
  - That cycle, the fetch request still passes to memory.
  - Next cycle: state IDLE, wr_ptr=0, pending flag cleared, run=0.
  - host_halt outside RUN is ignored.
- Memory full without host_wr_last: after 2^(ADDR_WIDTH+1) words, the block forces last behaviour and wr_ptr wraps to 0. No further beats are accepted until the next IDLE.
- Reset mid-LOAD discards any pending half-line (no flush). Lines already written stay in memory.
- Reset during RUN drops run the cycle after rst is sampled.

Optional Feature:
- Macro: IMEM_DROP_ERR_EN.
- When defined:
  - Adds output drop_err (1 bit), a sticky flag set when ifu_mem_ce=1 in any state other than RUN.
  - Cleared by rst or by the transition IDLE->LOAD.
  - Reset value 0.
- When undefined, the port and its logic are absent; dropped requests are silent.

Test Plan:
- Load 4 words D0..D3 (D3 last, boot 12'h013):
  - Writes {D1,D0} to line 0 and {D3,D2} to line 1 on the D1 and D3 beats.
  - BOOT pulse start_vld=1, start_addr=12'h010, one cycle later; then run=1.
- Load 3 words (odd count):
  - FLUSH writes {64'b0,D2} to line 1 the cycle after the D2 beat, then BOOT.
- In RUN, ifu_mem_ce=1 with ifu_mem_addr=8'h05 -> mem_ce=1, mem_addr=8'h05, mem_we=0 in the same cycle.
- Raise host_halt together with an ifu_mem_ce request:
  - The request reaches memory that cycle.
  - Next cycle: IDLE, run=0, host_wr_rdy=1.
  - A new load restarts at line 0.
- Stream 512 words with no last -> line 255 written on word 511, BOOT follows, host_wr_rdy=0 afterwards.
- Assert rst after 1 word of a load -> no memory write, all outputs 0, state IDLE. With IMEM_DROP_ERR_EN, ifu_mem_ce during LOAD sets drop_err=1, which stays set until the next load begins.
